// File: rtl/kamacore_pkg.sv
// Core-wide sizing shared by the kamacore memory subsystem.
package kamacore_pkg;
  parameter int CPU_WIDTH  = 32;
  parameter int ADDR_WIDTH = 8;
endpackage

// File: rtl/kamacore_mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the memory's read/write port.
interface kamacore_mem_arbiter_if #(
  parameter int ADDR_W = kamacore_pkg::ADDR_WIDTH
);
  import kamacore_pkg::CPU_WIDTH;

  logic                  m0_valid;
  logic                  m0_we;
  logic                  m0_lock;
  logic [ADDR_W-1:0]     m0_addr;
  logic [CPU_WIDTH-1:0]  m0_wdata;
  logic                  m0_ready;
  logic                  m0_rvalid;

  logic                  m1_valid;
  logic                  m1_we;
  logic                  m1_lock;
  logic [ADDR_W-1:0]     m1_addr;
  logic [CPU_WIDTH-1:0]  m1_wdata;
  logic                  m1_ready;
  logic                  m1_rvalid;

  logic [CPU_WIDTH-1:0]  rdata;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_a;
  logic [CPU_WIDTH-1:0]  mem_di;
  logic [CPU_WIDTH-1:0]  mem_spo;

  modport slave (
    input  m0_valid, m0_we, m0_lock, m0_addr, m0_wdata,
    input  m1_valid, m1_we, m1_lock, m1_addr, m1_wdata,
    input  mem_spo,
    output m0_ready, m0_rvalid, m1_ready, m1_rvalid,
    output rdata, mem_we, mem_a, mem_di
  );

  modport master (
    output m0_valid, m0_we, m0_lock, m0_addr, m0_wdata,
    output m1_valid, m1_we, m1_lock, m1_addr, m1_wdata,
    output mem_spo,
    input  m0_ready, m0_rvalid, m1_ready, m1_rvalid,
    input  rdata, mem_we, mem_a, mem_di
  );
endinterface

// File: rtl/kamacore_mem_arbiter.sv
// Round-robin arbiter with burst lock sharing the kamacore memory read/write port
// between the load/store unit (m0) and the debug loader (m1); reads return one cycle later.
module kamacore_mem_arbiter #(
  parameter int MEM_ADDR_WIDTH = kamacore_pkg::ADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  kamacore_mem_arbiter_if.slave  bus
);
  import kamacore_pkg::CPU_WIDTH;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  prio_q, prio_d;
  logic [CPU_WIDTH-1:0]  rdata_q, rdata_d;
  logic                  rsel_q, rsel_d;
  logic                  rpend_q, rpend_d;

  logic                  gnt0;
  logic                  gnt1;
  logic                  acc_read;
  logic [MEM_ADDR_WIDTH-1:0] mem_a_sel;
  logic [CPU_WIDTH-1:0]  mem_di_sel;

  // State register: FSM, priority pointer and read-response pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB;
      prio_q  <= 1'b0;
      rdata_q <= '0;
      rsel_q  <= 1'b0;
      rpend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      rdata_q <= rdata_d;
      rsel_q  <= rsel_d;
      rpend_q <= rpend_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    unique case (state_q)
      ARB: begin
        if (gnt0) begin
          if (bus.m0_lock) state_d = LOCK0;
          else             prio_d  = 1'b1;
        end else if (gnt1) begin
          if (bus.m1_lock) state_d = LOCK1;
          else             prio_d  = 1'b0;
        end
      end
      LOCK0: begin
        // Lock released on a final beat or while idle; both hand priority over.
        if (!bus.m0_lock) begin
          state_d = ARB;
          prio_d  = 1'b1;
        end
      end
      LOCK1: begin
        if (!bus.m1_lock) begin
          state_d = ARB;
          prio_d  = 1'b0;
        end
      end
      default: begin
        state_d = ARB;
      end
    endcase

    rpend_d = acc_read;
    rsel_d  = acc_read ? gnt1 : rsel_q;
    rdata_d = acc_read ? bus.mem_spo : rdata_q;
  end

  // Output logic: winner selection and port drive.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case (state_q)
      ARB: begin
        gnt0 = bus.m0_valid & (~bus.m1_valid | ~prio_q);
        gnt1 = bus.m1_valid & (~bus.m0_valid |  prio_q);
      end
      LOCK0:   gnt0 = bus.m0_valid;
      LOCK1:   gnt1 = bus.m1_valid;
      default: begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
      end
    endcase

    acc_read   = (gnt0 & ~bus.m0_we) | (gnt1 & ~bus.m1_we);
    mem_a_sel  = gnt1 ? bus.m1_addr  : bus.m0_addr;
    mem_di_sel = gnt1 ? bus.m1_wdata : bus.m0_wdata;

    // Handshake outputs are masked by rst_n so nothing is granted while reset is held.
    bus.m0_ready  = gnt0 & rst_n;
    bus.m1_ready  = gnt1 & rst_n;
    bus.mem_we    = rst_n & ((gnt0 & bus.m0_we) | (gnt1 & bus.m1_we));
    bus.mem_a     = mem_a_sel;
    bus.mem_di    = mem_di_sel;
    bus.m0_rvalid = rpend_q & ~rsel_q;
    bus.m1_rvalid = rpend_q &  rsel_q;
    bus.rdata     = rdata_q;
  end

endmodule

// File: tb/tb_kamacore_mem_arbiter.sv
// Directed bench for kamacore_mem_arbiter: vector table plus reset sequences,
// with a behavioural memory on the read/write port.
module tb_kamacore_mem_arbiter;
  import kamacore_pkg::*;

  typedef struct {
    logic        v0, we0, l0;
    logic [7:0]  a0;
    logic [31:0] d0;
    logic        v1, we1, l1;
    logic [7:0]  a1;
    logic [31:0] d1;
    logic        r0, r1, rv0, rv1, mwe;
    logic [31:0] rd;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] mem [256];

  kamacore_mem_arbiter_if #(.ADDR_W(8)) bus ();

  kamacore_mem_arbiter #(.MEM_ADDR_WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_a] <= bus.mem_di;
  end
  assign bus.mem_spo = mem[bus.mem_a];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic v0, we0, l0, input logic [7:0] a0, input logic [31:0] d0,
    input logic v1, we1, l1, input logic [7:0] a1, input logic [31:0] d1,
    input logic r0, r1, rv0, rv1, mwe, input logic [31:0] rd);
    vec_t v;
    v.v0 = v0; v.we0 = we0; v.l0 = l0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.we1 = we1; v.l1 = l1; v.a1 = a1; v.d1 = d1;
    v.r0 = r0; v.r1 = r1; v.rv0 = rv0; v.rv1 = rv1; v.mwe = mwe; v.rd = rd;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.m0_valid = v.v0; bus.m0_we = v.we0; bus.m0_lock = v.l0;
    bus.m0_addr  = v.a0; bus.m0_wdata = v.d0;
    bus.m1_valid = v.v1; bus.m1_we = v.we1; bus.m1_lock = v.l1;
    bus.m1_addr  = v.a1; bus.m1_wdata = v.d1;
  endtask

  task automatic compare(input string tag, input vec_t v);
    chk({tag, " m0_ready"},  {31'd0, bus.m0_ready},  {31'd0, v.r0});
    chk({tag, " m1_ready"},  {31'd0, bus.m1_ready},  {31'd0, v.r1});
    chk({tag, " m0_rvalid"}, {31'd0, bus.m0_rvalid}, {31'd0, v.rv0});
    chk({tag, " m1_rvalid"}, {31'd0, bus.m1_rvalid}, {31'd0, v.rv1});
    chk({tag, " mem_we"},    {31'd0, bus.mem_we},    {31'd0, v.mwe});
    chk({tag, " rdata"},     bus.rdata,              v.rd);
  endtask

  vec_t vecs[24];
  vec_t idle_v;
  vec_t cur;

  initial begin
    idle_v = mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0);
    //            m0: v we l a d          m1: v we l a d            r0 r1 rv0 rv1 we rdata
    vecs[0]  = mk(1,1,0,5,32'hAA,   1,1,0,6,32'hBB,   1,0,0,0,1,32'h0);
    vecs[1]  = mk(0,0,0,0,0,        1,1,0,6,32'hBB,   0,1,0,0,1,32'h0);
    vecs[2]  = mk(1,0,0,5,0,        0,0,0,0,0,        1,0,0,0,0,32'h0);
    vecs[3]  = mk(0,0,0,0,0,        1,0,0,6,0,        0,1,1,0,0,32'hAA);
    vecs[4]  = mk(0,0,0,0,0,        0,0,0,0,0,        0,0,0,1,0,32'hBB);
    vecs[5]  = mk(0,0,0,0,0,        0,0,0,0,0,        0,0,0,0,0,32'hBB);
    vecs[6]  = mk(0,0,0,0,0,        1,1,1,10,32'h100, 0,1,0,0,1,32'hBB);
    vecs[7]  = mk(1,0,0,5,0,        1,1,1,11,32'h101, 0,1,0,0,1,32'hBB);
    vecs[8]  = mk(1,0,0,5,0,        1,1,1,12,32'h102, 0,1,0,0,1,32'hBB);
    vecs[9]  = mk(1,0,0,5,0,        1,1,0,13,32'h103, 0,1,0,0,1,32'hBB);
    vecs[10] = mk(1,0,0,5,0,        0,0,0,0,0,        1,0,0,0,0,32'hBB);
    vecs[11] = mk(0,0,0,0,0,        0,0,0,0,0,        0,0,1,0,0,32'hAA);
    vecs[12] = mk(1,1,0,20,32'h1234,0,0,0,0,0,        1,0,0,0,1,32'hAA);
    vecs[13] = mk(1,0,0,20,0,       0,0,0,0,0,        1,0,0,0,0,32'hAA);
    vecs[14] = mk(0,0,0,0,0,        0,0,0,0,0,        0,0,1,0,0,32'h1234);
    vecs[15] = mk(0,0,0,0,0,        1,0,0,12,0,       0,1,0,0,0,32'h1234);
    vecs[16] = mk(1,0,0,13,0,       0,0,0,0,0,        1,0,0,1,0,32'h102);
    vecs[17] = mk(0,0,0,0,0,        0,0,0,0,0,        0,0,1,0,0,32'h103);
    vecs[18] = mk(1,1,1,30,32'h55,  0,0,0,0,0,        1,0,0,0,1,32'h103);
    vecs[19] = mk(0,0,1,0,0,        1,0,0,30,0,       0,0,0,0,0,32'h103);
    vecs[20] = mk(0,0,0,0,0,        1,0,0,30,0,       0,0,0,0,0,32'h103);
    vecs[21] = mk(1,0,0,5,0,        1,0,0,30,0,       0,1,0,0,0,32'h103);
    vecs[22] = mk(1,0,0,5,0,        0,0,0,0,0,        1,0,0,1,0,32'h55);
    vecs[23] = mk(0,0,0,0,0,        0,0,0,0,0,        0,0,1,0,0,32'hAA);

    // Reset held with both requesters asking to write.
    drive(mk(1,1,0,5,32'hAA, 1,1,0,6,32'hBB, 0,0,0,0,0,0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    compare("reset_hold", idle_v);
    $display("txn reset_hold: ready=%0b/%0b mem_we=%0b rdata=0x%0h",
             bus.m0_ready, bus.m1_ready, bus.mem_we, bus.rdata);
    @(posedge clk); #1;
    drive(idle_v);
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      drive(vecs[i]);
      @(negedge clk);
      compare($sformatf("vec%0d", i), vecs[i]);
      $display("txn vec%0d: ready=%0b/%0b rvalid=%0b/%0b mem_we=%0b mem_a=%0d rdata=0x%0h",
               i, bus.m0_ready, bus.m1_ready, bus.m0_rvalid, bus.m1_rvalid,
               bus.mem_we, bus.mem_a, bus.rdata);
    end

    // Reset asserted in LOCK1 right after a locked read was accepted.
    @(posedge clk); #1;
    cur = mk(0,0,0,0,0, 1,1,1,40,32'h77, 0,1,0,0,1,32'hAA);
    drive(cur);
    @(negedge clk);
    compare("lock1_wr", cur);
    $display("txn lock1_wr: m1_ready=%0b", bus.m1_ready);
    @(posedge clk); #1;
    cur = mk(0,0,0,0,0, 1,0,1,40,0, 0,1,0,0,0,32'hAA);
    drive(cur);
    @(negedge clk);
    compare("lock1_rd", cur);
    $display("txn lock1_rd: m1_ready=%0b", bus.m1_ready);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    compare("mid_reset", idle_v);
    $display("txn mid_reset: rvalid=%0b/%0b rdata=0x%0h", bus.m0_rvalid, bus.m1_rvalid, bus.rdata);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("mid_reset_hold%0d m1_rvalid", k), {31'd0, bus.m1_rvalid}, 32'd0);
      chk($sformatf("mid_reset_hold%0d m1_ready", k),  {31'd0, bus.m1_ready},  32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    cur = mk(1,0,0,5,0, 1,0,0,6,0, 1,0,0,0,0,32'h0);
    drive(cur);
    @(negedge clk);
    compare("post_reset_tie", cur);
    $display("txn post_reset_tie: ready=%0b/%0b", bus.m0_ready, bus.m1_ready);
    @(posedge clk); #1;
    drive(idle_v);
    cur = mk(0,0,0,0,0, 0,0,0,0,0, 0,0,1,0,0,32'hAA);
    @(negedge clk);
    compare("post_reset_resp", cur);
    $display("txn post_reset_resp: rvalid=%0b/%0b rdata=0x%0h",
             bus.m0_rvalid, bus.m1_rvalid, bus.rdata);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/kamacore_mem_arbiter.md
# kamacore_mem_arbiter

Two-requester arbiter that shares the single read/write port (`we`, `a`, `di`, `spo`) of the kamacore dual-port memory. Requester 0 is the core load/store unit and requester 1 is the debug/program loader. The arbiter grants at most one transfer per cycle using round-robin priority, and supports a lock for uninterrupted bursts. It returns read data through a registered, one-cycle-latency response. The memory's second read port (`dpra`/`dpo`, instruction fetch) is not touched by this block.

## Interface
- `MEM_ADDR_WIDTH`, default `ADDR_WIDTH`: address width, matches the memory's `a`.
- Data width is `CPU_WIDTH` from the core package. It is not a parameter.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `m0_valid`, `m1_valid`  in  1  requester has a transfer pending.
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read.
- `m0_lock`, `m1_lock`  in  1  hold the grant after this transfer.
- `m0_addr`, `m1_addr`  in  MEM_ADDR_WIDTH  word address.
- `m0_wdata`, `m1_wdata`  in  CPU_WIDTH  write data.
- `m0_ready`, `m1_ready`  out  1  transfer accepted this cycle (combinational).
- `m0_rvalid`, `m1_rvalid`  out  1  read response valid (one-cycle pulse).
- `rdata`  out  CPU_WIDTH  registered read data, shared by both requesters.
- `mem_we`  out  1  drives memory `we`.
- `mem_a`  out  MEM_ADDR_WIDTH  drives memory `a`.
- `mem_di`  out  CPU_WIDTH  drives memory `di`.
- `mem_spo`  in  CPU_WIDTH  memory `spo`; asynchronous read of `mem_a`.

## Operation
- **State:**
  - FSM `ARB`, `LOCK0`, `LOCK1`.
  - `prio` (1 bit; 0 means m0 wins a tie).
  - Response registers `rdata`, `rsel`, `rpend`.
- **Winner selection:**
  - `ARB`: if only one requester is valid, it wins. If both are valid, `m<prio>` wins.
  - `LOCKx`: only mx can win. The other requester's `ready` is 0 even if `mx_valid` = 0.
- **Outputs:**
  - `ready` = 1 for the winner only, and never during reset.
  - `mem_a` and `mem_di` follow the winner. With no winner, they hold m0's inputs.
  - `mem_we` = winner's `we` when a winner exists, else 0.
- **Accepted read:** `rdata <= mem_spo` at the accepting edge, and the winner's `rvalid` is 1 for exactly the next cycle. Both `rvalid` outputs are never 1 together.
- **Accepted write:** memory is updated at the accepting edge. No response is generated.
- **Round-robin:** after an accepted transfer with lock = 0, `prio` is set to the other requester. A transfer with lock = 1 leaves `prio` unchanged.
- **FSM transitions:**
  - `ARB -> LOCKx`: mx is accepted with `mx_lock` = 1.
  - `LOCKx -> ARB`: in any cycle where `mx_lock` = 0. This covers both an accepted last beat with lock = 0 and lock dropped while idle. On exit, `prio` = other requester.
  - In `LOCKx` with `mx_valid` = 0 and `mx_lock` = 1, the FSM stays in `LOCKx` and the port idles.
- **`rdata`** holds its value until the next accepted read.
- **Reset** (asynchronous, any cycle, including mid-burst or with a response pending):
  - FSM = `ARB`, `prio` = 0, `rdata` = 0.
  - Both `rvalid` = 0, both `ready` = 0, `mem_we` = 0.
  - A pending read response is dropped.

## Timing
- Grant latency is 0 cycles: `ready` is asserted in the same cycle as `valid` when the requester wins.
- Read latency is 1 cycle: a read accepted in cycle N produces `rvalid`/`rdata` in cycle N+1.
- Throughput is 1 transfer per cycle, back-to-back, for either requester or alternating.
- Read after write to the same address in consecutive cycles returns the new data, because the write commits at the edge before the read samples `spo`.
- Requesters must hold `valid`, `we`, `addr`, `wdata` and `lock` stable until `ready` = 1.
- `rvalid` has no backpressure; the requester must take `rdata` in the `rvalid` cycle.
- No combinational path from `mem_spo` to any output.
- `mem_spo` to `rdata` is the only path through the memory.

## Test plan
- **Reset:** hold `rst_n` = 0 with both valid -> `m0_ready` = `m1_ready` = 0, `mem_we` = 0, both `rvalid` = 0, `rdata` = 0.
- **Tie-break:** after reset, both requesters write at once (m0: addr 5 ← 0xAA, m1: addr 6 ← 0xBB) -> m0 accepted in cycle 1, m1 in cycle 2. Reads then return 0xAA and 0xBB.
- **Read latency:** m1 reads addr 6 in cycle N -> `m1_rvalid` = 1 and `rdata` = 0xBB in cycle N+1, `m0_rvalid` = 0, `rvalid` = 0 in N+2.
- **Lock burst:** m1 locks and writes addrs 10–13 while m0 is valid continuously -> `m0_ready` = 0 for 4 cycles. m0 is accepted in the cycle after m1's last (unlocked) beat.
- **Read after write:** m0 writes 0x1234 to addr 20 in cycle N and reads addr 20 in cycle N+1 -> `rdata` = 0x1234 with `m0_rvalid` in cycle N+2.
- **Reset mid-operation:** assert `rst_n` = 0 in `LOCK1` with a read response pending -> `rvalid` never asserts. After release, the FSM is in `ARB` and m0 wins the first tie.
